// File: rtl/cs_accum_pkg.sv
// Shared types and constants for the carry-save packet accumulator.
// Default geometry lives here so the top and the resolve slice agree on it.
package cs_accum_pkg;

    localparam int P_SIZE_DEF = 16;
    localparam int CHUNK_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    localparam int N_CHUNK = P_SIZE_DEF / CHUNK_DEF;

    // Width of a counter that indexes n items, never narrower than one bit.
    function automatic int k_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int K_W = k_width(N_CHUNK);

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

endpackage

// File: rtl/cs_resolve.sv
// Chunked carry-propagate stage: resolves s + c2 one CHUNK-bit slice per cycle,
// LSB slice first, carrying between slices in cy_reg.
module cs_resolve
    import cs_accum_pkg::*;
#(
    parameter int P_SIZE = P_SIZE_DEF,
    parameter int CHUNK  = CHUNK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              en,
    input  logic              clr,
    input  logic [P_SIZE-1:0] s,
    input  logic [P_SIZE-1:0] c2,
    output logic [P_SIZE-1:0] r,
    output logic              last
);

    localparam int NC = P_SIZE / CHUNK;
    localparam int KW = k_width(NC);

    logic [KW-1:0]    k_reg;
    logic             cy_reg;
    logic [CHUNK-1:0] s_ch [NC];
    logic [CHUNK-1:0] c_ch [NC];
    logic [CHUNK-1:0] r_ch [NC];
    logic [CHUNK:0]   sum_next;

    assign sum_next = {1'b0, s_ch[k_reg]} + {1'b0, c_ch[k_reg]} + {{CHUNK{1'b0}}, cy_reg};
    assign last     = (k_reg == KW'(NC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg  <= '0;
            cy_reg <= 1'b0;
        end else if (start) begin
            k_reg  <= '0;
            cy_reg <= 1'b0;
        end else if (en) begin
            k_reg  <= k_reg + KW'(1);
            cy_reg <= sum_next[CHUNK];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_chunk
            assign s_ch[gi] = s[gi*CHUNK +: CHUNK];
            assign c_ch[gi] = c2[gi*CHUNK +: CHUNK];
            assign r[gi*CHUNK +: CHUNK] = r_ch[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ch[gi] <= '0;
                end else if (clr) begin
                    r_ch[gi] <= '0;
                end else if (en && (k_reg == KW'(gi))) begin
                    r_ch[gi] <= sum_next[CHUNK-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ip_tree.sv
// Bitwise 3:2 compressor: out0 + 2*out1 == a + b + c, with no carry ripple.
module ip_tree #(
    parameter int P_SIZE = 16
) (
    input  logic [P_SIZE-1:0] a,
    input  logic [P_SIZE-1:0] b,
    input  logic [P_SIZE-1:0] c,
    output logic [P_SIZE-1:0] out0,
    output logic [P_SIZE-1:0] out1
);

    genvar gi;
    generate
        for (gi = 0; gi < P_SIZE; gi++) begin : g_fa
            assign out0[gi] = a[gi] ^ b[gi] ^ c[gi];
            assign out1[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
        end
    endgenerate

endmodule

// File: rtl/cs_accum.sv
// Streaming packet accumulator: operands fold into a carry-save pair each beat;
// the pair is resolved to binary in chunks after the last beat of a packet.
module cs_accum
    import cs_accum_pkg::*;
#(
    parameter int P_SIZE = P_SIZE_DEF,
    parameter int CHUNK  = CHUNK_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [P_SIZE-1:0] in_data,
    input  logic              in_last,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [P_SIZE-1:0] out_sum,
    output logic [CNT_W-1:0]  out_cnt
);

    state_t            state_reg, state_next;
    logic [P_SIZE-1:0] s_reg, c_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [P_SIZE-1:0] c2, s_next, c_next;
    logic              accept, handshake, resolve_last;

    assign in_rdy    = (state_reg == ACCUM);
    assign out_vld   = (state_reg == DONE);
    assign accept    = in_vld && in_rdy;
    assign handshake = out_vld && out_rdy;
    assign c2        = c_reg << 1;
    assign out_cnt   = cnt_reg;

    ip_tree #(.P_SIZE(P_SIZE)) u_tree (
        .a    (in_data),
        .b    (s_reg),
        .c    (c2),
        .out0 (s_next),
        .out1 (c_next)
    );

    cs_resolve #(.P_SIZE(P_SIZE), .CHUNK(CHUNK)) u_resolve (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && in_last),
        .en    (state_reg == RESOLVE),
        .clr   (handshake),
        .s     (s_reg),
        .c2    (c2),
        .r     (out_sum),
        .last  (resolve_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && in_last) state_next = RESOLVE;
            RESOLVE: if (resolve_last)      state_next = DONE;
            DONE:    if (out_rdy)           state_next = ACCUM;
            default:                        state_next = ACCUM;
        endcase
    end

    // S/C stay frozen through RESOLVE and DONE so the resolve slice reads a stable pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            c_reg   <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            s_reg   <= s_next;
            c_reg   <= c_next;
            cnt_reg <= (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
        end else if (handshake) begin
            s_reg   <= '0;
            c_reg   <= '0;
            cnt_reg <= '0;
        end
    end

endmodule

// File: tb/tb_cs_accum.sv
// Directed and seeded-random bench for cs_accum against a packet-level sum model.
module tb_cs_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld, in_rdy, in_last;
    logic [15:0] in_data;
    logic        out_vld, out_rdy;
    logic [15:0] out_sum;
    logic [7:0]  out_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] pkt[$];

    cs_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .in_last (in_last),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_sum (out_sum),
        .out_cnt (out_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Packet-level model: running sum mod 2^16 and saturating count; results queue
    // up on the last beat and must appear 4 cycles later, held until accepted.
    int          exp_sum_q[$];
    int          exp_cnt_q[$];
    logic [15:0] acc_sum;
    int          acc_cnt;
    logic        busy;
    int          last_edge;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_sum_q.delete();
            exp_cnt_q.delete();
            acc_sum = 0;
            acc_cnt = 0;
            busy    = 1'b0;
            chk("rst_in_rdy",  in_rdy,  1);
            chk("rst_out_vld", out_vld, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_cnt", out_cnt, 0);
        end else begin
            chk("in_rdy",  in_rdy,  !busy);
            chk("out_vld", out_vld, busy && (cyc >= last_edge + 4));
            if (out_vld && exp_sum_q.size() > 0) begin
                chk("out_sum", out_sum, exp_sum_q[0]);
                chk("out_cnt", out_cnt, exp_cnt_q[0]);
                if (out_rdy) begin
                    void'(exp_sum_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                    busy = 1'b0;
                end
            end
            if (in_vld && in_rdy) begin
                acc_sum = acc_sum + in_data;
                acc_cnt = (acc_cnt == 255) ? 255 : acc_cnt + 1;
                if (in_last) begin
                    exp_sum_q.push_back(acc_sum);
                    exp_cnt_q.push_back(acc_cnt);
                    acc_sum   = 0;
                    acc_cnt   = 0;
                    busy      = 1'b1;
                    last_edge = cyc + 1;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the last beat's accept edge.
    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            int n = 0;
            in_vld  = 1'b1;
            in_data = pkt[i];
            in_last = (i == pkt.size() - 1);
            while (!in_rdy && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("accept_timeout", 1, 0);
            @(negedge clk);
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!out_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("result_timeout", 1, 0);
    endtask

    task automatic wait_result(input string nm, input logic [15:0] es, input logic [7:0] ec);
        wait_vld();
        chk({nm, "_sum"}, out_sum, es);
        chk({nm, "_cnt"}, out_cnt, ec);
        out_rdy = 1'b1;
        @(negedge clk);
        chk({nm, "_once"}, out_vld, 0);
        $display("packet %s: sum=%0h cnt=%0d", nm, es, ec);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        pkt = '{16'd11, 16'd22, 16'd33};
        send_pkt();
        wait_result("basic", 16'd66, 8'd3);

        pkt = '{16'hFFFF, 16'h0002};
        send_pkt();
        wait_result("wrap", 16'h0001, 8'd2);

        // Second packet's first beat is held valid through RESOLVE and DONE of the first.
        pkt = '{16'h1234};
        send_pkt();
        pkt = '{16'd5, 16'd7};
        send_pkt();
        wait_result("b2b", 16'd12, 8'd2);

        out_rdy = 1'b0;
        pkt = '{16'h0100, 16'h0023, 16'h1000};
        send_pkt();
        wait_vld();
        repeat (10) @(negedge clk);
        wait_result("bp", 16'h1123, 8'd3);

        pkt.delete();
        for (int i = 0; i < 300; i++) pkt.push_back(16'd1);
        send_pkt();
        wait_result("sat", 16'd300, 8'd255);

        void'($urandom(32'h5eed));
        for (int p = 0; p < 8; p++) begin
            int nb = $urandom_range(1, 20);
            pkt.delete();
            for (int i = 0; i < nb; i++) pkt.push_back(16'($urandom));
            send_pkt();
            wait_vld();
            @(negedge clk);
            $display("random packet %0d: beats=%0d", p, nb);
        end

        pkt = '{16'd1, 16'd2};
        send_pkt();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_rdy",  in_rdy,  1);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_out_sum", out_sum, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pkt = '{16'd3, 16'd4};
        send_pkt();
        wait_result("post_rst", 16'd7, 8'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
